// File: rtl/timer_capture_sched.sv
// -----------------------------------------------------------------------------
// timer_capture_sched
//
// Capture scheduler for the multi-channel timer. Capture requests from
// NB_CAPTURES requesters are latched into pending bits. A round-robin arbiter
// picks one pending channel at a time. The scheduler pulses that channel's
// capture strobe, waits CAP_LATENCY cycles, then reads the captured slice
// back. The value is pushed, tagged with its channel index, into a small
// first-word-fall-through record FIFO with a valid/ready interface. The
// block also owns the timer's run/stop level and the capture-bank reset pulse.
//
// Build option:
//   TIMER_CAPTURE_SCHED_DROP_CNT_EN - when defined, drop_cnt_out is a
//   saturating 8-bit count of merged requests. When undefined, it is tied
//   to 0 and no counter logic is built.
//
// Ports:
//   clk_in                 single clock
//   rst_in                 asynchronous active-high reset
//   start_cmd_in           start pulse (sets the run flag)
//   stop_cmd_in            stop pulse (clears the run flag; wins over start)
//   req_in                 per-requester one-cycle capture request
//   timer_start_out        registered run level to the timer
//   timer_rst_capture_out  one-cycle capture-bank reset on each stop->run edge
//   timer_capture_out      one-hot, one-cycle capture strobe
//   timer_captured_in      timer capture registers, channel i at
//                          [i*TIMER_BITWIDTH +: TIMER_BITWIDTH]
//   rec_valid_out          record FIFO head valid
//   rec_ready_in           consumer ready (pop on valid && ready)
//   rec_data_out           captured value at the FIFO head
//   rec_idx_out            channel index at the FIFO head
//   busy_out               FSM not idle, or at least one request pending
//   drop_cnt_out           merged-request counter
// -----------------------------------------------------------------------------
module timer_capture_sched #(
  parameter int TIMER_BITWIDTH = 32,
  parameter int NB_CAPTURES    = 10,
  parameter int CAP_LATENCY    = 1,
  parameter int FIFO_DEPTH     = 4,
  localparam int IDX_W         = $clog2(NB_CAPTURES)
) (
  input  logic                                  clk_in,
  input  logic                                  rst_in,
  input  logic                                  start_cmd_in,
  input  logic                                  stop_cmd_in,
  input  logic [NB_CAPTURES-1:0]                req_in,
  output logic                                  timer_start_out,
  output logic                                  timer_rst_capture_out,
  output logic [NB_CAPTURES-1:0]                timer_capture_out,
  input  logic [NB_CAPTURES*TIMER_BITWIDTH-1:0] timer_captured_in,
  output logic                                  rec_valid_out,
  input  logic                                  rec_ready_in,
  output logic [TIMER_BITWIDTH-1:0]             rec_data_out,
  output logic [IDX_W-1:0]                      rec_idx_out,
  output logic                                  busy_out,
  output logic [7:0]                            drop_cnt_out
);

  localparam int CNT_W  = $clog2(CAP_LATENCY + 1);
  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int FCNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int REC_W  = IDX_W + TIMER_BITWIDTH;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STROBE = 2'd1,
    ST_WAIT   = 2'd2
  } state_t;

  // ---------------------------------------------------------------------------
  // Declarations
  // ---------------------------------------------------------------------------
  state_t                   state_reg, state_next;
  logic [CNT_W-1:0]         cnt_reg, cnt_next;
  logic                     run_reg, run_next;
  logic                     rst_capture_reg;
  logic [NB_CAPTURES-1:0]   capture_reg;
  logic                     busy_reg;
  logic [NB_CAPTURES-1:0]   pending_reg, pending_next;
  logic [IDX_W-1:0]         last_grant_reg;
  logic [IDX_W-1:0]         winner;
  logic                     winner_found;
  logic                     grant;
  logic                     push;
  logic                     pop;
  logic [NB_CAPTURES-1:0]   grant_mask;

  logic [TIMER_BITWIDTH-1:0] slice [NB_CAPTURES];

  logic [REC_W-1:0]         mem [FIFO_DEPTH];
  logic [PTR_W-1:0]         wr_ptr_reg, wr_ptr_next;
  logic [PTR_W-1:0]         rd_ptr_reg, rd_ptr_next;
  logic [FCNT_W-1:0]        fifo_count_reg, fifo_count_next;
  logic [FCNT_W-1:0]        count_after_pop;
  logic                     fifo_has_space;
  logic [REC_W-1:0]         push_rec;
  logic [REC_W-1:0]         head_rec;
  logic                     rec_valid_reg;
  logic [TIMER_BITWIDTH-1:0] rec_data_reg;
  logic [IDX_W-1:0]         rec_idx_reg;

  // ---------------------------------------------------------------------------
  // Unpack the timer capture bus into per-channel slices
  // ---------------------------------------------------------------------------
  genvar gi;
  generate
    for (gi = 0; gi < NB_CAPTURES; gi++) begin : g_slice
      assign slice[gi] = timer_captured_in[gi*TIMER_BITWIDTH +: TIMER_BITWIDTH];
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Run flag: stop wins over start
  // ---------------------------------------------------------------------------
  always_comb begin
    run_next = run_reg;
    if (stop_cmd_in) begin
      run_next = 1'b0;
    end else if (start_cmd_in) begin
      run_next = 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Round-robin arbiter: first pending channel at or after last_grant+1
  // ---------------------------------------------------------------------------
  always_comb begin
    int cand;
    cand         = 0;
    winner       = '0;
    winner_found = 1'b0;
    for (int k = 0; k < NB_CAPTURES; k++) begin
      cand = int'(last_grant_reg) + 1 + k;
      if (cand >= NB_CAPTURES) begin
        cand = cand - NB_CAPTURES;
      end
      if (!winner_found && pending_reg[IDX_W'(cand)]) begin
        winner       = IDX_W'(cand);
        winner_found = 1'b1;
      end
    end
  end

  assign fifo_has_space = (fifo_count_reg < FCNT_W'(FIFO_DEPTH));

  // ---------------------------------------------------------------------------
  // Capture sequencing FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_reg <= ST_IDLE;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    grant      = 1'b0;
    push       = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        // Only one capture is ever in flight, so free space at grant time
        // guarantees the FIFO cannot overflow when the record arrives.
        if (run_reg && winner_found && fifo_has_space) begin
          grant      = 1'b1;
          state_next = ST_STROBE;
        end
      end
      ST_STROBE: begin
        state_next = ST_WAIT;
        cnt_next   = CNT_W'(CAP_LATENCY);
      end
      ST_WAIT: begin
        if (cnt_reg <= CNT_W'(1)) begin
          push       = 1'b1;
          state_next = ST_IDLE;
        end else begin
          cnt_next = cnt_reg - 1'b1;
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  always_comb begin
    grant_mask = '0;
    if (grant) begin
      grant_mask[winner] = 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Pending bits. A request in the cycle its channel is granted re-arms the
  // bit rather than being merged into the grant.
  // ---------------------------------------------------------------------------
  always_comb begin
    pending_next = pending_reg;
    if (stop_cmd_in) begin
      pending_next = '0;
    end else if (run_reg) begin
      pending_next = (pending_reg & ~grant_mask) | req_in;
    end
  end

  // ---------------------------------------------------------------------------
  // Control registers and registered outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      run_reg         <= 1'b0;
      rst_capture_reg <= 1'b0;
      capture_reg     <= '0;
      busy_reg        <= 1'b0;
      pending_reg     <= '0;
      last_grant_reg  <= IDX_W'(NB_CAPTURES - 1);
    end else begin
      run_reg         <= run_next;
      rst_capture_reg <= run_next & ~run_reg;
      capture_reg     <= grant_mask;
      busy_reg        <= (state_next != ST_IDLE) || (|pending_next);
      pending_reg     <= pending_next;
      if (grant) begin
        last_grant_reg <= winner;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Record FIFO (first-word-fall-through with a registered head)
  // last_grant_reg names the channel in flight for the whole STROBE/WAIT span.
  // ---------------------------------------------------------------------------
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(FIFO_DEPTH - 1)) begin
      return '0;
    end
    return p + 1'b1;
  endfunction

  assign pop      = rec_valid_reg & rec_ready_in;
  assign push_rec = {last_grant_reg, slice[last_grant_reg]};

  always_comb begin
    wr_ptr_next     = push ? ptr_inc(wr_ptr_reg) : wr_ptr_reg;
    rd_ptr_next     = pop  ? ptr_inc(rd_ptr_reg) : rd_ptr_reg;
    count_after_pop = pop  ? (fifo_count_reg - 1'b1) : fifo_count_reg;
    fifo_count_next = push ? (count_after_pop + 1'b1) : count_after_pop;
    // If nothing older survives the pop, the new head is the record being
    // pushed this cycle; it is not in the storage array yet.
    if (count_after_pop == '0) begin
      head_rec = push_rec;
    end else begin
      head_rec = mem[rd_ptr_next];
    end
  end

  always_ff @(posedge clk_in) begin
    if (push) begin
      mem[wr_ptr_reg] <= push_rec;
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      wr_ptr_reg     <= '0;
      rd_ptr_reg     <= '0;
      fifo_count_reg <= '0;
      rec_valid_reg  <= 1'b0;
      rec_data_reg   <= '0;
      rec_idx_reg    <= '0;
    end else begin
      wr_ptr_reg     <= wr_ptr_next;
      rd_ptr_reg     <= rd_ptr_next;
      fifo_count_reg <= fifo_count_next;
      rec_valid_reg  <= (fifo_count_next != '0);
      // Head registers hold their last value while the FIFO is empty.
      if (fifo_count_next != '0) begin
        rec_idx_reg  <= head_rec[REC_W-1 -: IDX_W];
        rec_data_reg <= head_rec[TIMER_BITWIDTH-1:0];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Merged-request counter
  // ---------------------------------------------------------------------------
`ifdef TIMER_CAPTURE_SCHED_DROP_CNT_EN
  logic [7:0]             drop_cnt_reg;
  logic [NB_CAPTURES-1:0] drop_vec;
  int                     drop_sum;

  always_comb begin
    drop_vec = '0;
    if (run_reg && !stop_cmd_in) begin
      drop_vec = req_in & pending_reg & ~grant_mask;
    end
    drop_sum = int'(drop_cnt_reg);
    for (int k = 0; k < NB_CAPTURES; k++) begin
      drop_sum = drop_sum + int'(drop_vec[k]);
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      drop_cnt_reg <= '0;
    end else if (drop_sum > 255) begin
      drop_cnt_reg <= 8'hFF;
    end else begin
      drop_cnt_reg <= 8'(drop_sum);
    end
  end

  assign drop_cnt_out = drop_cnt_reg;
`else
  assign drop_cnt_out = 8'd0;
`endif

  // ---------------------------------------------------------------------------
  // Output assignments
  // ---------------------------------------------------------------------------
  assign timer_start_out       = run_reg;
  assign timer_rst_capture_out = rst_capture_reg;
  assign timer_capture_out     = capture_reg;
  assign rec_valid_out         = rec_valid_reg;
  assign rec_data_out          = rec_data_reg;
  assign rec_idx_out           = rec_idx_reg;
  assign busy_out              = busy_reg;

endmodule

// File: tb/tb_timer_capture_sched.sv
// -----------------------------------------------------------------------------
// tb_timer_capture_sched
//
// Self-checking bench for timer_capture_sched with default parameters.
// A cycle-indexed vector table covers reset, start and the first capture;
// hand-written sequences cover round-robin order, merging, FIFO full, stop
// during a capture and asynchronous reset during WAIT. The fake timer drives
// every slice i with {cycle, i}, so a record's value reveals the cycle in
// which it was sampled.
// -----------------------------------------------------------------------------
module tb_timer_capture_sched;

  localparam int NB = 10;
  localparam int TW = 32;
  localparam int IW = 4;

`ifdef TIMER_CAPTURE_SCHED_DROP_CNT_EN
  localparam logic [7:0] EXP_DROP = 8'd1;
`else
  localparam logic [7:0] EXP_DROP = 8'd0;
`endif

  logic             clk_in = 1'b0;
  logic             rst_in;
  logic             start_cmd_in;
  logic             stop_cmd_in;
  logic [NB-1:0]    req_in;
  logic             timer_start_out;
  logic             timer_rst_capture_out;
  logic [NB-1:0]    timer_capture_out;
  logic [NB*TW-1:0] timer_captured_in;
  logic             rec_valid_out;
  logic             rec_ready_in;
  logic [TW-1:0]    rec_data_out;
  logic [IW-1:0]    rec_idx_out;
  logic             busy_out;
  logic [7:0]       drop_cnt_out;

  int cyc;
  int n_pass;
  int n_total;

  timer_capture_sched dut (
    .clk_in                (clk_in),
    .rst_in                (rst_in),
    .start_cmd_in          (start_cmd_in),
    .stop_cmd_in           (stop_cmd_in),
    .req_in                (req_in),
    .timer_start_out       (timer_start_out),
    .timer_rst_capture_out (timer_rst_capture_out),
    .timer_capture_out     (timer_capture_out),
    .timer_captured_in     (timer_captured_in),
    .rec_valid_out         (rec_valid_out),
    .rec_ready_in          (rec_ready_in),
    .rec_data_out          (rec_data_out),
    .rec_idx_out           (rec_idx_out),
    .busy_out              (busy_out),
    .drop_cnt_out          (drop_cnt_out)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    logic          start;
    logic [NB-1:0] req;
    logic          exp_start;
    logic          exp_rstcap;
    logic [NB-1:0] exp_cap;
    logic          exp_valid;
    logic [IW-1:0] exp_idx;
    logic [TW-1:0] exp_data;
    logic          exp_busy;
  } vec_t;

  vec_t vecs[16];

  function automatic logic [NB-1:0] oh(input int i);
    logic [NB-1:0] one;
    one = 1;
    return one << i;
  endfunction

  // Value the fake timer shows on slice ch during cycle t.
  function automatic logic [TW-1:0] sval(input int t, input int ch);
    return 32'(t * 256 + ch);
  endfunction

  task automatic update_bus();
    for (int i = 0; i < NB; i++) begin
      timer_captured_in[i*TW +: TW] = sval(cyc, i);
    end
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
    cyc++;
    update_bus();
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic do_reset();
    rst_in       = 1'b1;
    start_cmd_in = 1'b0;
    stop_cmd_in  = 1'b0;
    req_in       = '0;
    rec_ready_in = 1'b0;
    @(posedge clk_in);
    #1;
    @(posedge clk_in);
    #1;
    rst_in = 1'b0;
    cyc    = 0;
    update_bus();
  endtask

  task automatic do_start();
    start_cmd_in = 1'b1;
    tick();
    start_cmd_in = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int r;
    int nstrobe;
    int nrec;
    int last_c;
    int seen;
    n_pass  = 0;
    n_total = 0;
    cyc     = 0;
    timer_captured_in = '0;

    // ------------------------------------------------------------------
    // Table: reset state, start at cycle 5, request ch3 at cycle 10
    // ------------------------------------------------------------------
    for (int k = 0; k < 16; k++) begin
      vecs[k].start      = 1'b0;
      vecs[k].req        = '0;
      vecs[k].exp_start  = (k >= 6);
      vecs[k].exp_rstcap = (k == 6);
      vecs[k].exp_cap    = '0;
      vecs[k].exp_valid  = 1'b0;
      vecs[k].exp_idx    = '0;
      vecs[k].exp_data   = '0;
      vecs[k].exp_busy   = 1'b0;
    end
    vecs[5].start     = 1'b1;
    vecs[10].req      = 10'h008;
    vecs[11].exp_busy = 1'b1;
    vecs[12].exp_cap  = 10'h008;
    vecs[12].exp_busy = 1'b1;
    vecs[13].exp_busy = 1'b1;
    vecs[14].exp_valid = 1'b1;
    vecs[14].exp_idx   = 4'd3;
    vecs[14].exp_data  = 32'h0000_0D03;

    do_reset();
    rec_ready_in = 1'b1;
    chk("reset_data", rec_data_out, 0);
    chk("reset_idx", rec_idx_out, 0);
    chk("reset_drop", drop_cnt_out, 0);
    for (int k = 0; k < 16; k++) begin
      start_cmd_in = vecs[k].start;
      req_in       = vecs[k].req;
      $display("vec %0d: start=%0d cap=%h valid=%0d idx=%0d data=%h busy=%0d",
               k, timer_start_out, timer_capture_out, rec_valid_out,
               rec_idx_out, rec_data_out, busy_out);
      chk("vec_start", timer_start_out, vecs[k].exp_start);
      chk("vec_rstcap", timer_rst_capture_out, vecs[k].exp_rstcap);
      chk("vec_capture", timer_capture_out, vecs[k].exp_cap);
      chk("vec_valid", rec_valid_out, vecs[k].exp_valid);
      chk("vec_busy", busy_out, vecs[k].exp_busy);
      if (vecs[k].exp_valid) begin
        chk("vec_idx", rec_idx_out, vecs[k].exp_idx);
        chk("vec_data", rec_data_out, vecs[k].exp_data);
      end
      tick();
    end
    start_cmd_in = 1'b0;
    req_in       = '0;

    // ------------------------------------------------------------------
    // Round-robin: all channels requested in one cycle
    // ------------------------------------------------------------------
    do_reset();
    do_start();
    rec_ready_in = 1'b1;
    r = cyc;
    req_in = '1;
    tick();
    req_in  = '0;
    nstrobe = 0;
    nrec    = 0;
    last_c  = 0;
    for (int c = 1; c < 50; c++) begin
      if (timer_capture_out != '0) begin
        chk("rr_strobe", timer_capture_out, oh(nstrobe));
        if (nstrobe == 0) begin
          chk("rr_first_latency", c, 2);
        end else begin
          chk("rr_spacing", c - last_c, 3);
        end
        last_c = c;
        nstrobe++;
      end
      if (rec_valid_out) begin
        $display("rr record: idx=%0d data=%h", rec_idx_out, rec_data_out);
        chk("rr_idx", rec_idx_out, nrec);
        chk("rr_data", rec_data_out, sval(r + 3 + 3 * nrec, nrec));
        nrec++;
      end
      tick();
    end
    chk("rr_strobe_count", nstrobe, 10);
    chk("rr_rec_count", nrec, 10);
    chk("rr_drop", drop_cnt_out, 0);

    // ------------------------------------------------------------------
    // Request in the grant cycle re-arms (two records, no drop);
    // request while pending is merged (one record, one drop)
    // ------------------------------------------------------------------
    do_reset();
    do_start();
    rec_ready_in = 1'b1;
    req_in = 10'h020;
    tick();
    req_in = 10'h020;
    tick();
    req_in = '0;
    nrec = 0;
    for (int c = 0; c < 30; c++) begin
      if (rec_valid_out) begin
        $display("rearm record: idx=%0d data=%h", rec_idx_out, rec_data_out);
        chk("rearm_idx", rec_idx_out, 5);
        nrec++;
      end
      tick();
    end
    chk("rearm_recs", nrec, 2);
    chk("rearm_drop", drop_cnt_out, 0);

    req_in = 10'h001;
    tick();
    req_in = 10'h004;
    tick();
    req_in = 10'h004;
    tick();
    req_in = '0;
    nrec = 0;
    for (int c = 0; c < 30; c++) begin
      if (rec_valid_out) begin
        $display("merge record: idx=%0d data=%h", rec_idx_out, rec_data_out);
        chk("merge_idx", rec_idx_out, (nrec == 0) ? 0 : 2);
        nrec++;
      end
      tick();
    end
    chk("merge_recs", nrec, 2);
    chk("merge_drop", drop_cnt_out, EXP_DROP);

    // ------------------------------------------------------------------
    // FIFO full: 6 requests, consumer stalled
    // ------------------------------------------------------------------
    do_reset();
    do_start();
    rec_ready_in = 1'b0;
    r = cyc;
    req_in = 10'h03F;
    tick();
    req_in  = '0;
    nstrobe = 0;
    for (int c = 0; c < 40; c++) begin
      if (timer_capture_out != '0) begin
        nstrobe++;
      end
      tick();
    end
    chk("full_strobes", nstrobe, 4);
    chk("full_valid", rec_valid_out, 1);
    chk("full_head_idx", rec_idx_out, 0);
    chk("full_head_data", rec_data_out, sval(r + 3, 0));
    chk("full_busy", busy_out, 1);
    $display("full: popping one record idx=%0d", rec_idx_out);
    rec_ready_in = 1'b1;
    tick();
    rec_ready_in = 1'b0;
    nstrobe = 0;
    for (int c = 0; c < 20; c++) begin
      if (timer_capture_out != '0) begin
        chk("full_extra_strobe", timer_capture_out, oh(4));
        nstrobe++;
      end
      tick();
    end
    chk("full_extra_count", nstrobe, 1);
    chk("full_head_idx2", rec_idx_out, 1);
    chk("full_head_data2", rec_data_out, sval(r + 6, 1));

    // ------------------------------------------------------------------
    // Stop during WAIT with channels 1 and 4 pending
    // ------------------------------------------------------------------
    do_reset();
    do_start();
    rec_ready_in = 1'b1;
    tick();
    r = cyc;
    req_in = 10'h013;
    tick();
    req_in = '0;
    tick();
    chk("stop_strobe_ch0", timer_capture_out, oh(0));
    tick();
    chk("stop_wait_busy", busy_out, 1);
    stop_cmd_in = 1'b1;
    tick();
    stop_cmd_in = 1'b0;
    $display("stop record: idx=%0d data=%h", rec_idx_out, rec_data_out);
    chk("stop_run", timer_start_out, 0);
    chk("stop_valid", rec_valid_out, 1);
    chk("stop_idx", rec_idx_out, 0);
    chk("stop_data", rec_data_out, sval(r + 3, 0));
    chk("stop_busy", busy_out, 0);
    nrec    = 1;
    nstrobe = 0;
    req_in  = '1;
    tick();
    for (int c = 0; c < 10; c++) begin
      if (timer_capture_out != '0) nstrobe++;
      if (rec_valid_out) nrec++;
      tick();
    end
    req_in = '0;
    chk("stopped_strobes", nstrobe, 0);
    chk("stopped_recs", nrec, 1);
    chk("stopped_busy", busy_out, 0);
    do_start();
    chk("restart_rstcap", timer_rst_capture_out, 1);
    chk("restart_run", timer_start_out, 1);
    for (int c = 0; c < 12; c++) begin
      if (timer_capture_out != '0) nstrobe++;
      if (rec_valid_out) nrec++;
      tick();
    end
    chk("restart_strobes", nstrobe, 0);
    chk("restart_recs", nrec, 1);

    // ------------------------------------------------------------------
    // Asynchronous reset while in WAIT with 2 records held
    // ------------------------------------------------------------------
    do_reset();
    do_start();
    rec_ready_in = 1'b0;
    tick();
    req_in = 10'h007;
    tick();
    req_in = '0;
    for (int c = 0; c < 8; c++) begin
      tick();
    end
    chk("arst_pre_valid", rec_valid_out, 1);
    chk("arst_pre_busy", busy_out, 1);
    chk("arst_pre_cap", timer_capture_out, 0);
    #3;
    rst_in = 1'b1;
    #1;
    $display("async reset asserted mid-cycle");
    chk("arst_start", timer_start_out, 0);
    chk("arst_rstcap", timer_rst_capture_out, 0);
    chk("arst_cap", timer_capture_out, 0);
    chk("arst_valid", rec_valid_out, 0);
    chk("arst_data", rec_data_out, 0);
    chk("arst_idx", rec_idx_out, 0);
    chk("arst_busy", busy_out, 0);
    chk("arst_drop", drop_cnt_out, 0);
    @(posedge clk_in);
    #1;
    rst_in = 1'b0;
    cyc    = 0;
    update_bus();
    do_start();
    rec_ready_in = 1'b1;
    req_in = 10'h021;
    tick();
    req_in = '0;
    seen = 0;
    for (int c = 0; c < 10; c++) begin
      if (timer_capture_out != '0 && seen == 0) begin
        $display("post-reset first strobe: %h", timer_capture_out);
        chk("arst_next_grant", timer_capture_out, oh(0));
        seen = 1;
      end
      tick();
    end
    chk("arst_grant_seen", seen, 1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
